// File: rtl/knight_rider_pkg.sv
// Shared constants, direction type and one-hot helper for the Knight Rider LED scanner.
package knight_rider_pkg;

    localparam int unsigned NUM_LEDS = 8;
    localparam int unsigned POS_W    = $clog2(NUM_LEDS);

    localparam logic [NUM_LEDS-1:0] LEDS_RST = 8'h01;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return NUM_LEDS'(1) << p;
    endfunction

endpackage

// File: rtl/knight_rider_top_tick_gen.sv
// Prescaler: asserts tick for one cycle every CLK_DIV cycles, restarting from 0 on reset.
module tick_gen #(
    parameter int unsigned CLK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A one-bit counter is kept for CLK_DIV=1 so the compare below stays well-formed.
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt = '0;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/knight_rider_top.sv
// Zedboard "Knight Rider" LED scanner top: one lit LED bouncing between bit 0 and bit 7.
// Optional macro KNIGHT_RIDER_TRAIL_EN adds a second LED trailing one position behind.
module knight_rider_top #(
    parameter int unsigned CLK_DIV  = 10_000_000,
    parameter int unsigned NUM_LEDS = knight_rider_pkg::NUM_LEDS
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_LEDS-1:0] leds
);

    import knight_rider_pkg::*;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);

    logic             tick;
    logic [POS_W-1:0] pos    = '0;
    logic [POS_W-1:0] pos_next;
    dir_t             dir    = DIR_UP;
    dir_t             dir_next;
    logic [NUM_LEDS-1:0] leds_q = LEDS_RST;
    logic [NUM_LEDS-1:0] leds_next;
`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [POS_W-1:0] prev_pos = '0;
    logic [POS_W-1:0] prev_next;
`endif

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Direction flips on the same tick that lands on an end, so each end shows for one step.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (tick) begin
            if (dir == DIR_UP) begin
                pos_next = pos + POS_W'(1);
                if (pos_next == POS_MAX) dir_next = DIR_DOWN;
            end else begin
                pos_next = pos - POS_W'(1);
                if (pos_next == '0) dir_next = DIR_UP;
            end
        end
`ifdef KNIGHT_RIDER_TRAIL_EN
        prev_next = tick ? pos : prev_pos;
        leds_next = onehot(pos_next) | onehot(prev_next);
`else
        leds_next = onehot(pos_next);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos    <= '0;
            dir    <= DIR_UP;
            leds_q <= LEDS_RST;
`ifdef KNIGHT_RIDER_TRAIL_EN
            prev_pos <= '0;
`endif
        end else begin
            pos    <= pos_next;
            dir    <= dir_next;
            leds_q <= leds_next;
`ifdef KNIGHT_RIDER_TRAIL_EN
            prev_pos <= prev_next;
`endif
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_knight_rider_top.sv
// Scoreboard bench for knight_rider_top with CLK_DIV=4 and CLK_DIV=1 instances.
module tb_knight_rider_top;

    logic       clk = 1'b0;
    logic       rst4 = 1'b1;
    logic       rst1 = 1'b1;
    logic [7:0] leds4;
    logic [7:0] leds1;

    always #20 clk = ~clk;

    knight_rider_top #(.CLK_DIV(4)) u4 (.clk(clk), .rst(rst4), .leds(leds4));
    knight_rider_top #(.CLK_DIV(1)) u1 (.clk(clk), .rst(rst1), .leds(leds1));

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed LED pattern after k steps from reset, indexed by k mod 14.
    logic [7:0] SEQ [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] TRL [14] = '{8'h03, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60,
                             8'hC0, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06};
`ifdef KNIGHT_RIDER_TRAIL_EN
    localparam int MAXB = 2;
`else
    localparam int MAXB = 1;
`endif

    function automatic logic [7:0] exp_at(input int k);
`ifdef KNIGHT_RIDER_TRAIL_EN
        return TRL[k % 14];
`else
        return SEQ[k % 14];
`endif
    endfunction

    logic [7:0] q4 [$];
    logic [7:0] q1 [$];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: leds=%h required %h", nm, $time, act, req);
        end
    endtask

    task automatic check_bits(input string nm, input logic [7:0] v);
        int c;
        c = $countones(v);
        n_checks++;
        if (c < 1 || c > MAXB) begin
            n_fail++;
            $display("FAIL %s @%0t: %0d bits set in %h, required 1..%0d", nm, $time, c, v, MAXB);
        end
    endtask

    // Reset as seen by the DUT at the last rising edge.
    logic rst4_seen = 1'b1;
    logic rst1_seen = 1'b1;
    always @(posedge clk) begin
        rst4_seen <= rst4;
        rst1_seen <= rst1;
    end

    int cyc = 0;
    int ref4 = 0, ref1 = 0;
    logic [7:0] last4 = 8'h01, last1 = 8'h01;

    // Monitors: a step is due every CLK_DIV cycles after reset release; between steps leds must hold.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        check_bits("bits4", leds4);
        if (rst4_seen) begin
            check("reset4", leds4, 8'h01);
            ref4 = cyc;
        end else if (cyc - ref4 == 4) begin
            ref4 = cyc;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("step4", leds4, e);
            end
        end else begin
            check("hold4", leds4, last4);
        end
        last4 = leds4;

        check_bits("bits1", leds1);
        if (rst1_seen) begin
            check("reset1", leds1, 8'h01);
            ref1 = cyc;
        end else if (cyc - ref1 == 1) begin
            ref1 = cyc;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("step1", leds1, e);
            end
        end else begin
            check("hold1", leds1, last1);
        end
        last1 = leds1;
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (q4.size() != 0 || q1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q4.size(), q1.size());
        end
    endtask

    initial begin
        // Full sweep plus second sweep up to 20 heading down; covers both end reversals.
        for (int k = 1; k <= 23; k++) q4.push_back(exp_at(k));
        // Two full 14-step periods at CLK_DIV=1.
        for (int k = 1; k <= 28; k++) q1.push_back(exp_at(k));
        repeat (3) @(posedge clk);
        #1;
        rst4 = 1'b0;
        rst1 = 1'b0;
        wait_drain();

        @(posedge clk);
        #1 rst4 = 1'b1;
        for (int k = 1; k <= 3; k++) q4.push_back(exp_at(k));
        @(posedge clk);
        #1 rst4 = 1'b0;
        wait_drain();

        repeat (6) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
